ad7606_ctrl: RTL and testbench

- Parallel-interface conversion and readout controller for the AD7606 8-channel ADC.
- It consumes the periodic sample strobe from the sample-clock divider (about 153.4 kHz at 50 MHz) and issues CONVST.
- It waits out BUSY, then reads the 8 channel words over CS#/RD#.
- Each word is presented downstream as an indexed, single-cycle-valid sample stream with a frame-done marker.

---
 rtl/ad7606_ctrl_if.sv | 31 +++
 rtl/ad7606_ctrl.sv | 142 ++++++++++++++
 tb/tb_ad7606_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/ad7606_ctrl_if.sv
// AD7606 parallel bus plus the downstream indexed sample stream.
// master = controller side, slave = ADC / consumer side.
interface ad7606_ctrl_if;
  logic        sample_in;
  logic [15:0] ad_data;
  logic        ad_busy;
  logic        ad_frstdata;
  logic        ad_reset;
  logic        ad_convst;
  logic        ad_cs_n;
  logic        ad_rd_n;
  logic [2:0]  ad_os;
  logic [15:0] ch_data;
  logic [2:0]  ch_idx;
  logic        ch_valid;
  logic        frame_done;
  logic        overrun;
  logic        err;

  modport master (
    input  sample_in, ad_data, ad_busy, ad_frstdata,
    output ad_reset, ad_convst, ad_cs_n, ad_rd_n, ad_os,
           ch_data, ch_idx, ch_valid, frame_done, overrun, err
  );

  modport slave (
    output sample_in, ad_data, ad_busy, ad_frstdata,
    input  ad_reset, ad_convst, ad_cs_n, ad_rd_n, ad_os,
           ch_data, ch_idx, ch_valid, frame_done, overrun, err
  );
endinterface

// File: rtl/ad7606_ctrl.sv
// AD7606 conversion/readout controller: CONVST on sample edge, wait BUSY,
// read 8 words over CS#/RD#, emit indexed single-cycle-valid samples.
module ad7606_ctrl #(
  parameter int         RST_CYC      = 5,
  parameter int         CONV_LOW_CYC = 2,
  parameter int         RD_LOW_CYC   = 2,
  parameter int         RD_HIGH_CYC  = 2,
  parameter int         BUSY_TO      = 255,
  parameter logic [2:0] OS_RATIO     = 3'b000
) (
  input  logic          clk50,
  input  logic          rst_n,
  ad7606_ctrl_if.master bus
);
  // Sum of all cycle limits bounds every individual one, so no count wraps.
  localparam int CW = $clog2(RST_CYC + CONV_LOW_CYC + RD_LOW_CYC + RD_HIGH_CYC + BUSY_TO + 1);

  typedef enum logic [2:0] {AD_RST, IDLE, CONV, WAIT_BH, WAIT_BL, RD_L, RD_H} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    wcnt;
  logic [1:0]    smp_s, bsy_s, frst_s;
  logic          smp_prev;
  logic          smp_edge, busy, frst;

  assign smp_edge = smp_s[1] & ~smp_prev;
  assign busy     = bsy_s[1];
  assign frst     = frst_s[1];
  assign bus.ad_os = OS_RATIO;

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      smp_s    <= '0;
      bsy_s    <= '0;
      frst_s   <= '0;
      smp_prev <= 1'b0;
    end else begin
      smp_s    <= {smp_s[0], bus.sample_in};
      bsy_s    <= {bsy_s[0], bus.ad_busy};
      frst_s   <= {frst_s[0], bus.ad_frstdata};
      smp_prev <= smp_s[1];
    end
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state          <= AD_RST;
      cnt            <= '0;
      wcnt           <= '0;
      bus.ad_reset   <= 1'b1;
      bus.ad_convst  <= 1'b1;
      bus.ad_cs_n    <= 1'b1;
      bus.ad_rd_n    <= 1'b1;
      bus.ch_data    <= '0;
      bus.ch_idx     <= '0;
      bus.ch_valid   <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.overrun    <= 1'b0;
      bus.err        <= 1'b0;
    end else begin
      bus.ch_valid   <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.err        <= 1'b0;
      // Requests are never queued: any edge outside IDLE is dropped and flagged.
      bus.overrun    <= smp_edge && (state != IDLE) && (state != AD_RST);
      case (state)
        AD_RST: begin
          if (cnt == CW'(RST_CYC - 1)) begin
            bus.ad_reset <= 1'b0;
            cnt          <= '0;
            state        <= IDLE;
          end else cnt <= cnt + 1'b1;
        end
        IDLE: begin
          cnt <= '0;
          if (smp_edge) begin
            bus.ad_convst <= 1'b0;
            state         <= CONV;
          end
        end
        CONV: begin
          if (cnt == CW'(CONV_LOW_CYC - 1)) begin
            bus.ad_convst <= 1'b1;
            cnt           <= '0;
            state         <= WAIT_BH;
          end else cnt <= cnt + 1'b1;
        end
        WAIT_BH: begin
          if (busy) begin
            cnt   <= '0;
            state <= WAIT_BL;
          end else if (cnt == CW'(BUSY_TO - 1)) begin
            bus.err <= 1'b1;
            cnt     <= '0;
            state   <= IDLE;
          end else cnt <= cnt + 1'b1;
        end
        WAIT_BL: begin
          if (!busy) begin
            cnt         <= '0;
            wcnt        <= '0;
            bus.ad_cs_n <= 1'b0;
            bus.ad_rd_n <= 1'b0;
            state       <= RD_L;
          end else if (cnt == CW'(BUSY_TO - 1)) begin
            bus.err <= 1'b1;
            cnt     <= '0;
            state   <= IDLE;
          end else cnt <= cnt + 1'b1;
        end
        RD_L: begin
          if (cnt == CW'(RD_LOW_CYC - 1)) begin
            bus.ch_data    <= bus.ad_data;
            bus.ch_idx     <= wcnt;
            bus.ch_valid   <= 1'b1;
            bus.frame_done <= (wcnt == 3'd7);
            // FRSTDATA high only on the first word of the frame.
            bus.err        <= (wcnt == 3'd0) ? ~frst : frst;
            bus.ad_rd_n    <= 1'b1;
            cnt            <= '0;
            state          <= RD_H;
          end else cnt <= cnt + 1'b1;
        end
        RD_H: begin
          if (cnt == CW'(RD_HIGH_CYC - 1)) begin
            cnt <= '0;
            if (wcnt == 3'd7) begin
              bus.ad_cs_n <= 1'b1;
              state       <= IDLE;
            end else begin
              wcnt        <= wcnt + 1'b1;
              bus.ad_rd_n <= 1'b0;
              state       <= RD_L;
            end
          end else cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ad7606_ctrl.sv
// Directed bench for ad7606_ctrl with a behavioural AD7606 BUSY/data model.
module tb_ad7606_ctrl;
  logic clk50 = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk50 = ~clk50;

  ad7606_ctrl_if bus ();
  ad7606_ctrl dut (.clk50(clk50), .rst_n(rst_n), .bus(bus));

  int nchk = 0, nerr = 0;

  // ADC model: BUSY follows CONVST rise; word index advances on each RD# rise.
  int busy_mode = 0, busy_hi = 200, frst0 = 0, wi = 0;
  assign bus.ad_data     = 16'h1000 + wi[15:0];
  assign bus.ad_frstdata = (frst0 != 0) ? 1'b0 : (wi == 0);

  always begin
    @(posedge bus.ad_rd_n or negedge bus.ad_convst);
    if (!bus.ad_convst) wi = 0;
    else wi = wi + 1;
  end

  always begin
    @(posedge bus.ad_convst);
    if (busy_mode != 0) begin
      @(negedge clk50);
      bus.ad_busy = 1'b1;
      repeat (busy_hi) @(negedge clk50);
      bus.ad_busy = 1'b0;
    end
  end

  // Cumulative monitor; tests work on deltas.
  int cyc = 0, nv = 0, n_fd = 0, n_ov = 0, n_err = 0, n_cvlow = 0, n_cvfall = 0, n_cslow = 0;
  int err_cyc = 0, cv_rise = 0;
  logic cv_prev = 1'b1;
  int          vt [256];
  logic [15:0] vd [256];
  logic [2:0]  vi [256];
  logic        vf [256];
  logic        ve [256];

  always begin
    @(negedge clk50);
    cyc = cyc + 1;
    if (bus.ch_valid) begin
      if (nv < 256) begin
        vt[nv] = cyc; vd[nv] = bus.ch_data; vi[nv] = bus.ch_idx;
        vf[nv] = bus.frame_done; ve[nv] = bus.err;
      end
      nv = nv + 1;
    end
    if (bus.frame_done) n_fd = n_fd + 1;
    if (bus.overrun) n_ov = n_ov + 1;
    if (bus.err) begin n_err = n_err + 1; err_cyc = cyc; end
    if (!bus.ad_convst) n_cvlow = n_cvlow + 1;
    if (!bus.ad_convst && cv_prev) n_cvfall = n_cvfall + 1;
    if (bus.ad_convst && !cv_prev) cv_rise = cyc;
    if (!bus.ad_cs_n || !bus.ad_rd_n) n_cslow = n_cslow + 1;
    cv_prev = bus.ad_convst;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_sample();
    @(negedge clk50); bus.sample_in = 1'b1;
    repeat (3) @(negedge clk50);
    bus.sample_in = 1'b0;
  endtask

  task automatic wait_fd(input int target, input int maxc);
    int c = 0;
    while (n_fd < target && c < maxc) begin @(negedge clk50); c++; end
    if (n_fd < target) chk("timeout_frame_done", n_fd, target);
  endtask

  // Checks one complete frame starting at monitor entry b.
  task automatic chk_frame(input string tag, input int b);
    int bad = 0;
    for (int k = 0; k < 8; k++) begin
      if (vd[b+k] !== 16'h1000 + 16'(k) || vi[b+k] !== 3'(k) || vf[b+k] !== (k == 7)) bad++;
      if (k > 0 && vt[b+k] - vt[b+k-1] != 4) bad++;
    end
    chk(tag, bad, 0);
  endtask

  initial begin
    int b_nv, b_fd, b_ov, b_err, b_cvl, b_cvf, b_cs, hi, c, nv_at;
    bus.sample_in = 1'b0;
    bus.ad_busy   = 1'b0;

    // Reset state and ADC reset pulse width
    repeat (3) @(negedge clk50);
    chk("rst_ad_reset", bus.ad_reset, 1);
    chk("rst_strobes", {bus.ad_convst, bus.ad_cs_n, bus.ad_rd_n}, 3'b111);
    chk("rst_ch", {bus.ch_data, 13'd0, bus.ch_idx}, 0);
    chk("rst_pulses", {bus.ch_valid, bus.frame_done, bus.overrun, bus.err}, 0);
    chk("ad_os", bus.ad_os, 0);
    @(posedge clk50); #1 rst_n = 1'b1;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk50);
      if (bus.ad_reset) hi++; else break;
    end
    chk("ad_reset_cycles", hi, 5);
    b_cs = n_cslow; b_nv = nv;
    repeat (20) @(negedge clk50);
    chk("idle_strobes", n_cslow - b_cs + n_cvlow, 0);
    chk("idle_no_valid", nv - b_nv, 0);

    // Single frame
    busy_mode = 1;
    b_nv = nv; b_fd = n_fd; b_err = n_err; b_cvl = n_cvlow; b_cvf = n_cvfall; b_ov = n_ov;
    pulse_sample();
    wait_fd(b_fd + 1, 1000);
    repeat (10) @(negedge clk50);
    chk("f1_nvalid", nv - b_nv, 8);
    chk_frame("f1_words", b_nv);
    chk("f1_convst_low", n_cvlow - b_cvl, 2);
    chk("f1_convst_falls", n_cvfall - b_cvf, 1);
    chk("f1_err", n_err - b_err, 0);
    chk("f1_overrun", n_ov - b_ov, 0);

    // Ten frames at the nominal sample period
    b_nv = nv; b_fd = n_fd; b_ov = n_ov; b_err = n_err;
    for (int f = 0; f < 10; f++) begin
      pulse_sample();
      repeat (323) @(negedge clk50);
    end
    wait_fd(b_fd + 10, 500);
    begin
      int bad = 0;
      for (int k = 0; k < 80; k++)
        if (vi[b_nv+k] !== 3'(k % 8) || vd[b_nv+k] !== 16'h1000 + 16'(k % 8)) bad++;
      chk("f10_words", bad, 0);
    end
    chk("f10_nvalid", nv - b_nv, 80);
    chk("f10_nframes", n_fd - b_fd, 10);
    chk("f10_overrun", n_ov - b_ov, 0);
    chk("f10_err", n_err - b_err, 0);

    // Overrun: second edge while waiting for BUSY to fall
    b_nv = nv; b_fd = n_fd; b_ov = n_ov; b_cvf = n_cvfall;
    pulse_sample();
    repeat (60) @(negedge clk50);
    pulse_sample();
    wait_fd(b_fd + 1, 1000);
    repeat (20) @(negedge clk50);
    chk("ovr_pulses", n_ov - b_ov, 1);
    chk("ovr_nvalid", nv - b_nv, 8);
    chk_frame("ovr_words", b_nv);
    chk("ovr_convst_falls", n_cvfall - b_cvf, 1);

    // BUSY never rises: timeout, then normal recovery
    busy_mode = 0;
    b_nv = nv; b_err = n_err;
    pulse_sample();
    c = 0;
    while (n_err == b_err && c < 600) begin @(negedge clk50); c++; end
    chk("to_err", n_err - b_err, 1);
    chk("to_latency", err_cyc - cv_rise, 255);
    chk("to_nvalid", nv - b_nv, 0);
    busy_mode = 1;
    repeat (5) @(negedge clk50);
    b_nv = nv; b_fd = n_fd;
    pulse_sample();
    wait_fd(b_fd + 1, 1000);
    chk("to_recover", nv - b_nv, 8);

    // FRSTDATA stuck low
    frst0 = 1;
    repeat (10) @(negedge clk50);
    b_nv = nv; b_fd = n_fd; b_err = n_err;
    pulse_sample();
    wait_fd(b_fd + 1, 1000);
    repeat (5) @(negedge clk50);
    frst0 = 0;
    chk("fd0_nvalid", nv - b_nv, 8);
    chk("fd0_err_cnt", n_err - b_err, 1);
    chk("fd0_err_word0", ve[b_nv], 1);
    chk_frame("fd0_words", b_nv);

    // Reset asserted while reading word 3
    repeat (10) @(negedge clk50);
    b_nv = nv;
    pulse_sample();
    c = 0;
    while (!(nv - b_nv >= 3 && !bus.ad_rd_n) && c < 1000) begin @(negedge clk50); c++; end
    chk("mid_reached_word3", (nv - b_nv == 3 && !bus.ad_rd_n), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_async_strobes", {bus.ad_cs_n, bus.ad_rd_n, bus.ad_convst}, 3'b111);
    chk("mid_async_ad_reset", bus.ad_reset, 1);
    chk("mid_async_ch", {bus.ch_data, 13'd0, bus.ch_idx, 3'd0, bus.ch_valid}, 0);
    nv_at = nv;
    repeat (2) @(negedge clk50);
    @(posedge clk50); #1 rst_n = 1'b1;
    b_cs = n_cslow;
    repeat (400) @(negedge clk50);
    chk("mid_no_valid", nv - nv_at, 0);
    chk("mid_no_read", n_cslow - b_cs, 0);
    b_nv = nv; b_fd = n_fd;
    pulse_sample();
    wait_fd(b_fd + 1, 1000);
    chk("mid_recover", nv - b_nv, 8);
    chk_frame("mid_recover_words", b_nv);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
